// File: rtl/dll_pkg.sv
// Shared data-link-layer TX definitions.
//   - dlc_state_e : DLCMSM states as seen on the 2-bit dlc_state_i bus
//   - TLP_W/DLLP_W: beat and DLLP widths
//   - STARVE_LIMIT: DLLP grants tolerated while a TLP source waits (starve guard)
//   - grant_idx_e : bit positions of the one-hot grant vector {tlp,rpl,fc,acknak}
//   - elig_mask() : which requesters may be served in a given link state
package dll_pkg;

    localparam int TLP_W        = 1196;
    localparam int DLLP_W       = 48;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'b00,
        DL_FEATURE  = 2'b01,
        DL_INIT     = 2'b10,
        DL_ACTIVE   = 2'b11
    } dlc_state_e;

    typedef enum logic [1:0] {
        G_ACKNAK = 2'd0,
        G_FC     = 2'd1,
        G_RPL    = 2'd2,
        G_TLP    = 2'd3
    } grant_idx_e;

    // Flow-control DLLPs are already needed during DL_INIT; everything else
    // waits for DL_ACTIVE, and new TLPs also yield to an ongoing replay.
    function automatic logic [3:0] elig_mask(input dlc_state_e st, input logic rpl_busy);
        logic [3:0] m;
        m           = '0;
        m[G_ACKNAK] = (st == DL_ACTIVE);
        m[G_FC]     = (st == DL_INIT) || (st == DL_ACTIVE);
        m[G_RPL]    = (st == DL_ACTIVE);
        m[G_TLP]    = (st == DL_ACTIVE) && !rpl_busy;
        return m;
    endfunction

endpackage

// File: rtl/dll_tx_prio_sel.sv
// Combinational requester selection for the DLL TX arbiter.
// Masks the raw valids by link-state eligibility, then picks one winner with
// strict priority acknak > fc > rpl > tlp. When guard_i is set and a replay or
// new TLP is eligible, the TLP side (rpl > tlp) wins over the DLLPs.
// Ports:
//   state_i    : DLCMSM state
//   valid_i    : raw requests {tlp,rpl,fc,acknak}
//   rpl_busy_i : replay in progress (blocks new TLPs)
//   guard_i    : starve-guard override
//   grant_o    : one-hot winner, zero when nothing is eligible
module dll_tx_prio_sel
    import dll_pkg::*;
(
    input  dlc_state_e state_i,
    input  logic [3:0] valid_i,
    input  logic       rpl_busy_i,
    input  logic       guard_i,
    output logic [3:0] grant_o
);

    logic [3:0] req;

    always_comb begin
        req     = valid_i & elig_mask(state_i, rpl_busy_i);
        grant_o = '0;
        if (guard_i && (req[G_RPL] || req[G_TLP])) begin
            if (req[G_RPL]) grant_o[G_RPL] = 1'b1;
            else            grant_o[G_TLP] = 1'b1;
        end else if (req[G_ACKNAK]) begin
            grant_o[G_ACKNAK] = 1'b1;
        end else if (req[G_FC]) begin
            grant_o[G_FC] = 1'b1;
        end else if (req[G_RPL]) begin
            grant_o[G_RPL] = 1'b1;
        end else if (req[G_TLP]) begin
            grant_o[G_TLP] = 1'b1;
        end
    end

endmodule

// File: rtl/dll_tx_arbiter.sv
// Data-link-layer TX scheduler: shares one TLP_W-bit beat path between
// Ack/Nak DLLPs, InitFC/UpdateFC DLLPs, replay TLPs and new TLPs, behind a
// registered valid/ready output stage. DLLPs leave zero-extended so the far
// side classifies them by the all-zero upper bits.
// Optional feature: define DLL_TX_ARB_STARVE_GUARD_EN to add a 3-bit starve
// counter that forces one TLP-side grant after STARVE_LIMIT DLLP grants made
// while a replay/new TLP was waiting. Undefined: pure strict priority.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   dlc_state_i              : DLCMSM state (00 inactive .. 11 active)
//   acknak_*/fc_*            : DLLP requesters (payload, valid, ready)
//   rpl_*/tlp_*              : TLP requesters (payload, valid, ready)
//   rpl_busy_i               : replay in progress, blocks new TLPs
//   tx_data_o/tx_valid_o     : registered output beat
//   tx_ready_i               : downstream accepts beat
//   grant_o                  : one-hot {tlp,rpl,fc,acknak} owner of tx_data_o
module dll_tx_arbiter
    import dll_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        dlc_state_i,
    input  logic [DLLP_W-1:0] acknak_i,
    input  logic              acknak_valid_i,
    output logic              acknak_ready_o,
    input  logic [DLLP_W-1:0] fc_i,
    input  logic              fc_valid_i,
    output logic              fc_ready_o,
    input  logic [TLP_W-1:0]  rpl_i,
    input  logic              rpl_valid_i,
    output logic              rpl_ready_o,
    input  logic              rpl_busy_i,
    input  logic [TLP_W-1:0]  tlp_i,
    input  logic              tlp_valid_i,
    output logic              tlp_ready_o,
    output logic [TLP_W-1:0]  tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [3:0]        grant_o
);

    localparam int PAD_W = TLP_W - DLLP_W;

    dlc_state_e       st;
    logic [3:0]       src_valid;
    logic [3:0]       sel;
    logic [3:0]       xfer;
    logic             load;
    logic             guard;

    logic [TLP_W-1:0] tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [3:0]       grant_q, grant_d;

    assign st        = dlc_state_e'(dlc_state_i);
    assign src_valid = {tlp_valid_i, rpl_valid_i, fc_valid_i, acknak_valid_i};

    // The output register can take a new beat when empty or being drained.
    assign load = !tx_valid_q || tx_ready_i;

    dll_tx_prio_sel u_sel (
        .state_i    (st),
        .valid_i    (src_valid),
        .rpl_busy_i (rpl_busy_i),
        .guard_i    (guard),
        .grant_o    (sel)
    );

    // Ready doubles as the grant: a source transfers on valid & ready.
    assign xfer           = (load && !rst) ? sel : 4'b0000;
    assign acknak_ready_o = xfer[G_ACKNAK];
    assign fc_ready_o     = xfer[G_FC];
    assign rpl_ready_o    = xfer[G_RPL];
    assign tlp_ready_o    = xfer[G_TLP];

    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        grant_d    = grant_q;
        if (st == DL_INACTIVE) begin
            // Link down: any beat still waiting downstream is dropped.
            tx_valid_d = 1'b0;
            grant_d    = '0;
        end else if (load) begin
            tx_valid_d = |sel;
            grant_d    = sel;
            if (sel[G_ACKNAK])   tx_data_d = {{PAD_W{1'b0}}, acknak_i};
            else if (sel[G_FC])  tx_data_d = {{PAD_W{1'b0}}, fc_i};
            else if (sel[G_RPL]) tx_data_d = rpl_i;
            else if (sel[G_TLP]) tx_data_d = tlp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            grant_q    <= '0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            grant_q    <= grant_d;
        end
    end

`ifdef DLL_TX_ARB_STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;
    logic [3:0] req_all;
    logic       tlp_side_pend;

    assign req_all       = src_valid & elig_mask(st, rpl_busy_i);
    assign tlp_side_pend = req_all[G_RPL] || req_all[G_TLP];
    assign guard         = (starve_q == 3'(STARVE_LIMIT));

    // At the limit a pending TLP-side request always wins and clears the
    // count, so the counter never needs to saturate.
    always_comb begin
        starve_d = starve_q;
        if (st == DL_INACTIVE) begin
            starve_d = '0;
        end else if (load) begin
            if (sel[G_RPL] || sel[G_TLP])
                starve_d = '0;
            else if ((sel[G_ACKNAK] || sel[G_FC]) && tlp_side_pend)
                starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign guard = 1'b0;
`endif

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign grant_o    = grant_q;

endmodule
